alu_control_pipe: RTL and testbench
===================================

# alu_control_pipe

Parametrised, pipelined successor to the single-register ALU control decoder. It accepts one `{alu_op, funct}` pair per cycle over a valid/ready handshake and produces the 4-bit ALU control code through a registered output with a 2-entry skid buffer. It flags unsupported encodings and keeps a saturating illegal-operation counter. It sits between the main control unit and the ALU in the datapath.

## Interface
- `OP_W`, default 2: width of `alu_op`; must be ≥2.
- `FUNCT_W`, default 6: width of `funct`; must be ≥6.
- `CTL_W`, default 4: width of `alu_ctl`; must be ≥4, upper bits zero-filled.
- `ERR_CNT_W`, default 8: width of the illegal-operation counter.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: input transaction valid.
- `in_ready` out 1: block can accept a transaction.
- `alu_op` in `OP_W`: ALU operation class from the main control unit.
- `funct` in `FUNCT_W`: R-type function field.
- `out_valid` out 1: output transaction valid.
- `out_ready` in 1: ALU consumes the output.
- `alu_ctl` out `CTL_W`: decoded ALU control code.
- `illegal` out 1: current output came from an unsupported encoding.
- `err_clr` in 1: synchronous clear of `err_count`.
- `err_count` out `ERR_CNT_W`: saturating count of accepted illegal transactions.

## Operation
- **Accept:** a transaction is accepted on a rising edge when `in_valid && in_ready`. **Deliver:** a transaction is delivered when `out_valid && out_ready`.
- **Decode:**
  - Non-zero `alu_op[OP_W-1:2]` is illegal.
  - `alu_op[1:0]=00` → 0010 (add).
  - `01` → 0110 (sub).
  - `1x` → decode `funct[5:0]`; `funct[FUNCT_W-1:6]` must be zero, otherwise illegal.
- **R-type funct table:**
  - 100000 → 0010 (add)
  - 100001 → 0100 (rol)
  - 100010 → 0110 (sub)
  - 100011 → 0101 (ror)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
- **Illegal encoding:** `alu_ctl` = all-ones (1111) and `illegal`=1.
- **Storage:** two entries, main output register plus skid register; FIFO order is always preserved.
  - New accept, main empty or delivering, skid empty → goes to main.
  - New accept while main holds and is not delivering → goes to skid.
  - Main delivers while skid full → skid moves to main in the same edge.
  - `in_ready` = skid empty, registered from state. It is forced 0 while `rst`=1.
- **Error counter:**
  - +1 on each accepted illegal transaction (counted at accept, not delivery).
  - Saturates at 2^`ERR_CNT_W`−1.
  - `err_clr` sets it to 0. If `err_clr` coincides with an illegal accept, the result is 1.
- **Reset values:** `out_valid`=0, `alu_ctl`=0, `illegal`=0, `err_count`=0, skid empty.
  - `in_ready` is 0 during reset and 1 on the first cycle after.
  - Reset mid-operation discards both entries with no delivery.

## Timing
- **Latency:** 1 cycle. A transaction accepted at edge N is visible on `alu_ctl`/`out_valid` after edge N.
- **Throughput:** 1 transaction/cycle while `out_ready`=1.
- **Stability:** while `out_valid && !out_ready`, `alu_ctl` and `illegal` hold stable.
- **Backpressure:**
  - First stalled accept fills the skid; `in_ready` drops after that edge.
  - `in_ready` rises the cycle after the skid drains into main.
- **Simultaneous events:** accept and deliver in the same edge with skid empty → main is replaced, no bubble.
- **Inputs during reset:** `in_valid` is ignored while `rst`=1.

## Configuration
- `ALU_CTL_EXT_OPS_EN` defined adds these funct codes:
  - 100110 → 0011 (xor)
  - 100111 → 1100 (nor)
  - 101010 → 0111 (slt)
- Not defined: those three codes decode as illegal (1111, `illegal`=1, counted).

## Test plan
- Reset 3 cycles, then idle → `out_valid`=0, `alu_ctl`=0, `err_count`=0, `in_ready`=1 from the first post-reset cycle.
- Stream 00, 01, 10/100000, 10/100001, 10/100010, 10/100011, 10/100100, 10/100101 with `out_ready`=1 → outputs 0010, 0110, 0010, 0100, 0110, 0101, 0000, 0001 on consecutive cycles, `illegal`=0.
- Hold `out_ready`=0, offer 3 transactions → 2 accepted, `in_ready`=0. Raise `out_ready` → delivered in order, then 3rd accepted, no loss or duplication.
- `alu_op`=10, `funct`=111111, then `funct`=100110 → 1111 with `illegal`=1 for both when the macro is off (`err_count`=2). With the macro on, the second yields 0011 (`err_count`=1).
- `ERR_CNT_W`=2: five illegal accepts → `err_count` saturates at 3. `err_clr` with a simultaneous illegal accept → 1.
- Assert `rst` with both entries full → `out_valid`=0 next cycle, nothing delivered afterwards.

Source files
------------

// File: rtl/alu_control_pipe.sv
// ALU control decoder behind a valid/ready handshake with a 2-entry skid buffer and a saturating illegal-op counter.
// Latency 1 cycle; in_ready = skid empty and low while rst. Optional ALU_CTL_EXT_OPS_EN adds xor/nor/slt.
module alu_control_pipe #(
    parameter int OP_W      = 2,
    parameter int FUNCT_W   = 6,
    parameter int CTL_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTL_W-1:0]     alu_ctl,
    output logic                 illegal,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Returns {illegal, alu_ctl}; unsupported encodings give all-ones control.
    function automatic logic [CTL_W:0] decode(input logic [OP_W-1:0] op,
                                              input logic [FUNCT_W-1:0] fn);
        logic [3:0] code;
        logic       bad;
        code = 4'b0000;
        bad  = 1'b0;
        if ((op >> 2) != '0) begin
            bad = 1'b1;
        end else if (!op[1]) begin
            code = op[0] ? 4'b0110 : 4'b0010;
        end else if ((fn >> 6) != '0) begin
            bad = 1'b1;
        end else begin
            case (fn[5:0])
                6'b100000: code = 4'b0010;
                6'b100001: code = 4'b0100;
                6'b100010: code = 4'b0110;
                6'b100011: code = 4'b0101;
                6'b100100: code = 4'b0000;
                6'b100101: code = 4'b0001;
`ifdef ALU_CTL_EXT_OPS_EN
                6'b100110: code = 4'b0011;
                6'b100111: code = 4'b1100;
                6'b101010: code = 4'b0111;
`endif
                default:   bad  = 1'b1;
            endcase
        end
        if (bad) begin
            return {1'b1, {CTL_W{1'b1}}};
        end
        return {1'b0, CTL_W'(code)};
    endfunction

    logic             skid_vld;
    logic [CTL_W-1:0] skid_ctl;
    logic             skid_ill;
    logic [CTL_W-1:0] dec_ctl;
    logic             dec_ill;
    logic             accept;
    logic             main_free;

    assign {dec_ill, dec_ctl} = decode(alu_op, funct);
    assign in_ready  = !skid_vld && !rst;
    assign accept    = in_valid && in_ready;
    // Main register can take new data when empty or being consumed this edge.
    assign main_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_ctl   <= '0;
            illegal   <= 1'b0;
            skid_vld  <= 1'b0;
            skid_ctl  <= '0;
            skid_ill  <= 1'b0;
            err_count <= '0;
        end else begin
            if (main_free) begin
                if (skid_vld) begin
                    out_valid <= 1'b1;
                    alu_ctl   <= skid_ctl;
                    illegal   <= skid_ill;
                    skid_vld  <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    alu_ctl   <= dec_ctl;
                    illegal   <= dec_ill;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_vld <= 1'b1;
                skid_ctl <= dec_ctl;
                skid_ill <= dec_ill;
            end

            // A clear coinciding with an illegal accept still counts that accept.
            if (err_clr) begin
                err_count <= (accept && dec_ill) ? ERR_CNT_W'(1) : '0;
            end else if (accept && dec_ill && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: default instance plus a 2-bit error counter instance for saturation.
module tb_alu_control_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, illegal, err_clr;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [3:0] alu_ctl;
    logic [7:0] err_count;

    logic       in_valid2, in_ready2, out_valid2, out_ready2, illegal2, err_clr2;
    logic [1:0] alu_op2;
    logic [5:0] funct2;
    logic [3:0] alu_ctl2;
    logic [1:0] err_count2;

    int ncmp = 0;
    int nerr = 0;
    logic [3:0] delivered[$];

    always #5 clk = ~clk;

    alu_control_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctl(alu_ctl), .illegal(illegal), .err_clr(err_clr), .err_count(err_count)
    );

    alu_control_pipe #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .alu_op(alu_op2), .funct(funct2), .out_valid(out_valid2), .out_ready(out_ready2),
        .alu_ctl(alu_ctl2), .illegal(illegal2), .err_clr(err_clr2), .err_count(err_count2)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) delivered.push_back(alu_ctl);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_valid2 = 1'b0; alu_op2 = 2'b00; funct2 = 6'b0; out_ready2 = 1'b1; err_clr2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        rst = 1'b0;
        #1;
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        ncmp++; if (alu_ctl !== 4'b0000) begin nerr++; $display("FAIL reset_alu_ctl: got %b want 0000", alu_ctl); end
        ncmp++; if (illegal !== 1'b0) begin nerr++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        ncmp++; if (err_count !== 8'd0) begin nerr++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        step();
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream;
        logic [1:0] ops[8];
        logic [5:0] fns[8];
        logic [3:0] exp[8];
        ops = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        fns = '{6'b000000, 6'b111111, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101};
        exp = '{4'b0010, 4'b0110, 4'b0010, 4'b0100, 4'b0110, 4'b0101, 4'b0000, 4'b0001};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; funct = fns[i];
            step();
            ncmp++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            ncmp++; if (alu_ctl !== exp[i]) begin nerr++; $display("FAIL stream_ctl[%0d]: got %b want %b", i, alu_ctl, exp[i]); end
            ncmp++; if (illegal !== 1'b0) begin nerr++; $display("FAIL stream_illegal[%0d]: got %b want 0", i, illegal); end
            ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        delivered.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 2'b00; funct = 6'b0;
        step();
        ncmp++; if (alu_ctl !== 4'b0010) begin nerr++; $display("FAIL bp_first_ctl: got %b want 0010", alu_ctl); end
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
        alu_op = 2'b01;
        step();
        ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_skid_full_ready: got %b want 0", in_ready); end
        ncmp++; if (alu_ctl !== 4'b0010) begin nerr++; $display("FAIL bp_hold_ctl: got %b want 0010", alu_ctl); end
        alu_op = 2'b10; funct = 6'b100100;
        step();
        ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_third_blocked: got %b want 0", in_ready); end
        ncmp++; if (alu_ctl !== 4'b0010 || out_valid !== 1'b1) begin nerr++; $display("FAIL bp_stable: got %b/%b want 0010/1", alu_ctl, out_valid); end
        out_ready = 1'b1;
        step();
        ncmp++; if (alu_ctl !== 4'b0110) begin nerr++; $display("FAIL bp_skid_to_main: got %b want 0110", alu_ctl); end
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
        step();
        ncmp++; if (alu_ctl !== 4'b0000 || out_valid !== 1'b1) begin nerr++; $display("FAIL bp_third: got %b/%b want 0000/1", alu_ctl, out_valid); end
        in_valid = 1'b0;
        step();
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        ncmp++;
        if (delivered.size() != 3) begin
            nerr++; $display("FAIL bp_count: got %0d deliveries want 3", delivered.size());
        end else if (delivered[0] !== 4'b0010 || delivered[1] !== 4'b0110 || delivered[2] !== 4'b0000) begin
            nerr++; $display("FAIL bp_order: got %b %b %b want 0010 0110 0000", delivered[0], delivered[1], delivered[2]);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] exp_ctl;
        logic       exp_ill;
        logic [7:0] exp_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b111111;
        step();
        ncmp++; if (alu_ctl !== 4'b1111 || illegal !== 1'b1) begin nerr++; $display("FAIL ill_111111: got %b/%b want 1111/1", alu_ctl, illegal); end
        ncmp++; if (err_count !== 8'd1) begin nerr++; $display("FAIL ill_cnt1: got %0d want 1", err_count); end
`ifdef ALU_CTL_EXT_OPS_EN
        exp_ctl = 4'b0011; exp_ill = 1'b0; exp_cnt = 8'd1;
`else
        exp_ctl = 4'b1111; exp_ill = 1'b1; exp_cnt = 8'd2;
`endif
        funct = 6'b100110;
        step();
        ncmp++; if (alu_ctl !== exp_ctl || illegal !== exp_ill) begin nerr++; $display("FAIL ext_xor: got %b/%b want %b/%b", alu_ctl, illegal, exp_ctl, exp_ill); end
        ncmp++; if (err_count !== exp_cnt) begin nerr++; $display("FAIL ext_xor_cnt: got %0d want %0d", err_count, exp_cnt); end
        alu_op = 2'b11; funct = 6'b100101;
        step();
        ncmp++; if (alu_ctl !== 4'b0001 || illegal !== 1'b0) begin nerr++; $display("FAIL op11_or: got %b/%b want 0001/0", alu_ctl, illegal); end
        ncmp++; if (err_count !== exp_cnt) begin nerr++; $display("FAIL op11_cnt: got %0d want %0d", err_count, exp_cnt); end
`ifdef ALU_CTL_EXT_OPS_EN
        exp_ctl = 4'b0111;
`else
        exp_ctl = 4'b1111; exp_cnt = exp_cnt + 8'd1;
`endif
        alu_op = 2'b10; funct = 6'b101010;
        step();
        ncmp++; if (alu_ctl !== exp_ctl) begin nerr++; $display("FAIL ext_slt: got %b want %b", alu_ctl, exp_ctl); end
        ncmp++; if (err_count !== exp_cnt) begin nerr++; $display("FAIL ext_slt_cnt: got %0d want %0d", err_count, exp_cnt); end
        err_clr = 1'b1; alu_op = 2'b00; funct = 6'b0;
        step();
        ncmp++; if (err_count !== 8'd0) begin nerr++; $display("FAIL clr_legal: got %0d want 0", err_count); end
        alu_op = 2'b10; funct = 6'b111110;
        step();
        ncmp++; if (err_count !== 8'd1) begin nerr++; $display("FAIL clr_with_illegal: got %0d want 1", err_count); end
        err_clr = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_saturate;
        logic [1:0] exp_cnt;
        in_valid2 = 1'b1; alu_op2 = 2'b10; funct2 = 6'b111111; out_ready2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            ncmp++; if (err_count2 !== exp_cnt) begin nerr++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, err_count2, exp_cnt); end
        end
        ncmp++; if (alu_ctl2 !== 4'b1111 || illegal2 !== 1'b1) begin nerr++; $display("FAIL sat_ctl: got %b/%b want 1111/1", alu_ctl2, illegal2); end
        err_clr2 = 1'b1;
        step();
        ncmp++; if (err_count2 !== 2'd1) begin nerr++; $display("FAIL sat_clr_illegal: got %0d want 1", err_count2); end
        in_valid2 = 1'b0;
        step();
        ncmp++; if (err_count2 !== 2'd0) begin nerr++; $display("FAIL sat_clr_only: got %0d want 0", err_count2); end
        err_clr2 = 1'b0;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 2'b00; funct = 6'b0;
        step();
        alu_op = 2'b01;
        step();
        ncmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin nerr++; $display("FAIL mid_full: got ready %b valid %b want 0/1", in_ready, out_valid); end
        rst = 1'b1;
        step();
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
        step();
        ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_ignore_in: got %b want 0", out_valid); end
        delivered.delete();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        ncmp++; if (out_valid !== 1'b0 || delivered.size() != 0) begin nerr++; $display("FAIL mid_no_delivery: got valid %b count %0d want 0/0", out_valid, delivered.size()); end
        ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready_after: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_illegal();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
